// File: rtl/strait_sched_pkg.sv
// strait_sched_pkg: scheduler state enum, test phase codes and state classification helpers
package strait_sched_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_SELECT, S_MB_GO, S_MB_WAIT, S_LB_GO, S_LB_SA, S_LB_TD, S_REC_WAIT, S_TILE_END, S_DONE
  } state_e;
  typedef enum logic [1:0] {PH_MBIST, PH_LBIST_SA, PH_LBIST_TD, PH_REC} phase_e;
  function automatic logic is_wait(state_e s);
    return s inside {S_MB_WAIT, S_LB_SA, S_LB_TD, S_REC_WAIT};
  endfunction
  function automatic phase_e phase_of(state_e s);
    return s == S_LB_SA ? PH_LBIST_SA : s == S_LB_TD ? PH_LBIST_TD : s == S_REC_WAIT ? PH_REC : PH_MBIST;
  endfunction
endpackage

// File: rtl/strait_sched_watchdog.sv
// strait_sched_watchdog: reloadable down-counter (clk, rst_n, load, en in; expired out) flagging a wait that ran TIMEOUT_CYCLES cycles
module strait_sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  assign expired = en && cnt_q == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/strait_test_scheduler.sv
// strait_test_scheduler: per-tile MBIST/LBIST/BISR sequencer (host start/config + tile handshakes in; tile start/test_mode/bist_mode, busy/done/cur_tile and status masks out); STRAIT_SCHED_TIMEOUT_EN adds a per-wait watchdog
module strait_test_scheduler
  import strait_sched_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int TILE_IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_TILES-1:0]  tile_en_mask,
  input  logic                  run_mbist,
  input  logic                  run_lbist,
  input  logic [NUM_TILES-1:0]  tile_test_done,
  input  logic [NUM_TILES-1:0]  tile_mbist_result,
  input  logic [NUM_TILES-1:0]  tile_lbist_result,
  input  logic [NUM_TILES-1:0]  tile_recovery_done,
  input  logic [NUM_TILES-1:0]  tile_recovery_success,
  output logic [NUM_TILES-1:0]  tile_start,
  output logic [NUM_TILES-1:0]  tile_test_mode,
  output logic [NUM_TILES-1:0]  tile_bist_mode,
  output logic                  busy,
  output logic                  done,
  output logic [TILE_IDX_W-1:0] cur_tile,
  output logic [NUM_TILES-1:0]  pass_mask,
  output logic [NUM_TILES-1:0]  repaired_mask,
  output logic [NUM_TILES-1:0]  fail_mask,
  output logic [NUM_TILES-1:0]  timeout_mask
);
  state_e state_q, state_d;
  logic [TILE_IDX_W:0] idx_q, idx_d, sel_idx;
  logic [NUM_TILES-1:0] en_q, en_d, pass_q, pass_d, rep_q, rep_d, fail_q, fail_d, tmo_q, tmo_d, sel_oh;
  logic mb_q, mb_d, lb_q, lb_d, sel_found, ev, wd_exp;
  logic [TILE_IDX_W-1:0] cur;
  assign cur = idx_q[TILE_IDX_W-1:0];
  assign ev = is_wait(state_q) && ((phase_of(state_q) == PH_REC) ? tile_recovery_done[cur] : tile_test_done[cur]);
  always_comb begin
    sel_found = 1'b0;
    sel_idx = '0;
    for (int i = NUM_TILES - 1; i >= 0; i--)
      if (en_q[i] && (TILE_IDX_W + 1)'(i) >= idx_q) begin
        sel_found = 1'b1;
        sel_idx = (TILE_IDX_W + 1)'(i);
      end
  end
`ifdef STRAIT_SCHED_TIMEOUT_EN
  strait_sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TIMEOUT_W(TIMEOUT_W)) u_wd (
    .clk(clk), .rst_n(rst_n), .load(is_wait(state_d) && state_d != state_q), .en(is_wait(state_q)), .expired(wd_exp)
  );
`else
  assign wd_exp = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    en_d = en_q;
    mb_d = mb_q;
    lb_d = lb_q;
    pass_d = pass_q;
    rep_d = rep_q;
    fail_d = fail_q;
    tmo_d = tmo_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_SELECT;
        idx_d = '0;
        en_d = tile_en_mask;
        mb_d = run_mbist;
        lb_d = run_lbist;
        pass_d = '0;
        rep_d = '0;
        fail_d = '0;
        tmo_d = '0;
      end
      S_SELECT: begin
        state_d = (!sel_found || !(mb_q || lb_q)) ? S_DONE : mb_q ? S_MB_GO : S_LB_GO;
        idx_d = sel_found ? sel_idx : idx_q;
      end
      S_MB_GO: state_d = S_MB_WAIT;
      S_MB_WAIT: if (ev) begin
        state_d = (tile_mbist_result[cur] && lb_q) ? S_LB_GO : S_TILE_END;
        pass_d[cur] = tile_mbist_result[cur] && !lb_q;
        fail_d[cur] = !tile_mbist_result[cur];
      end
      S_LB_GO: state_d = S_LB_SA;
      S_LB_SA: if (ev) state_d = S_LB_TD;
      S_LB_TD: if (ev) begin
        state_d = tile_lbist_result[cur] ? S_TILE_END : S_REC_WAIT;
        pass_d[cur] = tile_lbist_result[cur];
      end
      S_REC_WAIT: if (ev) begin
        state_d = S_TILE_END;
        rep_d[cur] = tile_recovery_success[cur];
        fail_d[cur] = !tile_recovery_success[cur];
      end
      S_TILE_END: begin
        state_d = S_SELECT;
        idx_d = idx_q + 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (is_wait(state_q) && !ev && wd_exp) begin
      state_d = S_TILE_END;
      tmo_d[cur] = 1'b1;
      fail_d[cur] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      en_q <= '0;
      mb_q <= 1'b0;
      lb_q <= 1'b0;
      pass_q <= '0;
      rep_q <= '0;
      fail_q <= '0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      en_q <= en_d;
      mb_q <= mb_d;
      lb_q <= lb_d;
      pass_q <= pass_d;
      rep_q <= rep_d;
      fail_q <= fail_d;
      tmo_q <= tmo_d;
    end
  assign sel_oh = NUM_TILES'(1) << cur;
  assign tile_start = (state_q inside {S_MB_GO, S_LB_GO}) ? sel_oh : '0;
  assign tile_test_mode = (state_q inside {S_MB_GO, S_MB_WAIT, S_LB_GO, S_LB_SA, S_LB_TD, S_REC_WAIT}) ? sel_oh : '0;
  assign tile_bist_mode = (state_q inside {S_LB_GO, S_LB_SA, S_LB_TD, S_REC_WAIT}) ? sel_oh : '0;
  assign busy = !(state_q inside {S_IDLE, S_DONE});
  assign done = state_q == S_DONE;
  assign cur_tile = cur;
  assign pass_mask = pass_q;
  assign repaired_mask = rep_q;
  assign fail_mask = fail_q;
  assign timeout_mask = tmo_q;
endmodule

// File: tb/tb_strait_test_scheduler.sv
// tb_strait_test_scheduler: randomized tile responders and a per-tile outcome model checking the scheduler's masks, pulses and modes
module tb_strait_test_scheduler;
  localparam int N = 4;
`ifdef STRAIT_SCHED_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 8192;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, run_mbist = 1'b0, run_lbist = 1'b0;
  logic [N-1:0] tile_en_mask = '0, tile_test_done = '0, tile_mbist_result = '0, tile_lbist_result = '0;
  logic [N-1:0] tile_recovery_done = '0, tile_recovery_success = '0;
  logic [N-1:0] tile_start, tile_test_mode, tile_bist_mode, pass_mask, repaired_mask, fail_mask, timeout_mask;
  logic busy, done;
  logic [1:0] cur_tile;
  strait_test_scheduler #(.NUM_TILES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tile_en_mask(tile_en_mask), .run_mbist(run_mbist),
    .run_lbist(run_lbist), .tile_test_done(tile_test_done), .tile_mbist_result(tile_mbist_result),
    .tile_lbist_result(tile_lbist_result), .tile_recovery_done(tile_recovery_done),
    .tile_recovery_success(tile_recovery_success), .tile_start(tile_start), .tile_test_mode(tile_test_mode),
    .tile_bist_mode(tile_bist_mode), .busy(busy), .done(done), .cur_tile(cur_tile), .pass_mask(pass_mask),
    .repaired_mask(repaired_mask), .fail_mask(fail_mask), .timeout_mask(timeout_mask)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  bit mb_ok[N], lb_ok[N], rec_ok[N], hang[N];
  int step = 0, cnt = 0, tt = 0, viol = 0, done_cnt = 0, cyc = 0, start0_cyc = 0, tmo0_cyc = 0, last_lat = 0;
  int starts[N];
  logic [N-1:0] bist_seen = '0;
  initial forever begin
    @(negedge clk);
    cyc++;
    tile_test_done = '0;
    tile_recovery_done = '0;
    tile_mbist_result = N'($urandom);
    tile_lbist_result = N'($urandom);
    tile_recovery_success = N'($urandom);
    if (!rst_n) begin
      step = 0;
      continue;
    end
    for (int i = 0; i < N; i++) if (tile_start[i]) starts[i]++;
    bist_seen |= tile_bist_mode;
    if (!$onehot0(tile_start) || !$onehot0(tile_test_mode) || (tile_bist_mode & ~tile_test_mode) != '0 ||
        (tile_start & ~tile_test_mode) != '0 || (busy && done) ||
        (tile_test_mode != '0 && tile_test_mode != (N'(1) << cur_tile))) viol++;
    if (done) done_cnt++;
    if (tile_start[0]) start0_cyc = cyc;
    if (timeout_mask[0] && tmo0_cyc == 0) tmo0_cyc = cyc;
    for (int j = 0; j < N; j++) if (!tile_test_mode[j]) begin
      if ($urandom % 4 == 0) tile_test_done[j] = 1'b1;
      if ($urandom % 4 == 0) tile_recovery_done[j] = 1'b1;
    end
    if (tile_start != '0) begin
      for (int j = 0; j < N; j++) if (tile_start[j]) tt = j;
      step = tile_bist_mode[tt] ? 2 : 1;
      cnt = $urandom_range(1, 6);
      if ($urandom % 2 == 0) tile_test_done[tt] = 1'b1;
    end else if (step != 0) begin
      if (!(step == 1 && hang[tt])) cnt--;
      if (cnt == 0) begin
        case (step)
          1: begin
            tile_test_done[tt] = 1'b1;
            tile_mbist_result[tt] = mb_ok[tt];
            step = 0;
          end
          2: begin
            tile_test_done[tt] = 1'b1;
            step = 3;
            cnt = $urandom_range(1, 6);
          end
          3: begin
            tile_test_done[tt] = 1'b1;
            tile_lbist_result[tt] = lb_ok[tt];
            step = lb_ok[tt] ? 0 : 4;
            cnt = $urandom_range(1, 6);
          end
          default: begin
            tile_recovery_done[tt] = 1'b1;
            tile_recovery_success[tt] = rec_ok[tt];
            step = 0;
          end
        endcase
      end
    end
  end
  task automatic set_cfg(input bit rnd);
    for (int i = 0; i < N; i++) begin
      mb_ok[i] = rnd ? ($urandom % 4 != 0) : 1'b1;
      lb_ok[i] = rnd ? ($urandom % 4 != 0) : 1'b1;
      rec_ok[i] = rnd ? ($urandom % 2 != 0) : 1'b1;
      hang[i] = 1'b0;
    end
  endtask
  task automatic run_session(input string tag, input logic [N-1:0] m, input bit mb, input bit lb);
    bit seen = 1'b0;
    logic [N-1:0] ep = '0, er = '0, ef = '0, et = '0, eb = '0;
    logic [31:0] es = '0, gs = '0;
    for (int i = 0; i < N; i++) starts[i] = 0;
    bist_seen = '0;
    viol = 0;
    done_cnt = 0;
    start0_cyc = 0;
    tmo0_cyc = 0;
    tile_en_mask = m;
    run_mbist = mb;
    run_lbist = lb;
    start = 1'b1;
    last_lat = 0;
    while (!seen && last_lat < 4000) begin
      @(negedge clk);
      last_lat++;
      if (done) seen = 1'b1;
      else begin
        start = ($urandom % 8 == 0);
        tile_en_mask = N'($urandom);
        run_mbist = 1'($urandom);
        run_lbist = 1'($urandom);
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      int ns = 0;
      if (m[i] && (mb || lb)) begin
        if (mb) ns++;
        if (mb && hang[i]) begin
          et[i] = 1'b1;
          ef[i] = 1'b1;
        end else if (mb && !mb_ok[i]) ef[i] = 1'b1;
        else if (!lb) ep[i] = 1'b1;
        else begin
          ns++;
          eb[i] = 1'b1;
          if (lb_ok[i]) ep[i] = 1'b1;
          else if (rec_ok[i]) er[i] = 1'b1;
          else ef[i] = 1'b1;
        end
      end
      es[i*8 +: 8] = 8'(ns);
      gs[i*8 +: 8] = 8'(starts[i]);
    end
    check({tag, "_pass"}, 64'(pass_mask), 64'(ep));
    check({tag, "_repaired"}, 64'(repaired_mask), 64'(er));
    check({tag, "_fail"}, 64'(fail_mask), 64'(ef));
    check({tag, "_timeout"}, 64'(timeout_mask), 64'(et));
    check({tag, "_starts"}, 64'(gs), 64'(es));
    check({tag, "_bist_seen"}, 64'(bist_seen), 64'(eb));
    check({tag, "_out_viol"}, 64'(viol), 64'd0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask
  initial begin
    set_cfg(1'b0);
    #1 check("reset_outs", {tile_start, tile_test_mode, tile_bist_mode, busy, done, cur_tile, pass_mask,
                            repaired_mask, fail_mask, timeout_mask}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", {tile_start, tile_test_mode, tile_bist_mode, busy, done, cur_tile, pass_mask,
                        repaired_mask, fail_mask, timeout_mask}, 64'd0);
    run_session("all_pass", 4'b1111, 1'b1, 1'b1);
    set_cfg(1'b0);
    lb_ok[2] = 1'b0;
    run_session("repair2", 4'b1111, 1'b1, 1'b1);
    set_cfg(1'b0);
    mb_ok[1] = 1'b0;
    run_session("mbfail1", 4'b1111, 1'b1, 1'b1);
    set_cfg(1'b0);
    run_session("empty", 4'b0000, 1'b1, 1'b1);
    check("empty_latency", 64'(last_lat), 64'd2);
    run_session("no_phase", 4'b1011, 1'b0, 1'b0);
    check("no_phase_latency", 64'(last_lat), 64'd2);
    set_cfg(1'b1);
    run_session("mb_only", 4'b1111, 1'b1, 1'b0);
    set_cfg(1'b1);
    run_session("lb_only", 4'b1111, 1'b0, 1'b1);
`ifdef STRAIT_SCHED_TIMEOUT_EN
    set_cfg(1'b0);
    hang[0] = 1'b1;
    run_session("timeout0", 4'b0011, 1'b1, 1'b1);
    check("timeout0_latency", 64'(tmo0_cyc - start0_cyc), 64'(TO + 1));
`else
    check("timeout_tied", 64'(timeout_mask), 64'd0);
`endif
    for (int k = 0; k < 24; k++) begin
      logic [N-1:0] m = N'($urandom);
      bit mb = ($urandom % 4 != 0), lb = ($urandom % 4 != 0);
      set_cfg(1'b1);
      run_session($sformatf("rnd%0d", k), m, mb, lb);
      if (m == '0 || (!mb && !lb)) check($sformatf("rnd%0d_latency", k), 64'(last_lat), 64'd2);
    end
    set_cfg(1'b0);
    tile_en_mask = 4'b1111;
    run_mbist = 1'b1;
    run_lbist = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int w = 0;
      do begin
        @(negedge clk);
        #1 w++;
      end while (!(tt == 3 && step == 3) && w < 4000);
      check("rst_reach_td3", 64'(w < 4000), 64'd1);
    end
    @(negedge clk);
    check("rst_pre_busy", {busy, tile_bist_mode[3], tile_test_mode[3]}, 64'b111);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_outs", {tile_start, tile_test_mode, tile_bist_mode, busy, done, cur_tile, pass_mask,
                              repaired_mask, fail_mask, timeout_mask}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_cfg(1'b1);
    run_session("post_rst", 4'b1111, 1'b1, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
